// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, stage indices and stage payload types
package pipe_pkg;

    // Stall vector encoding: a set bit freezes that stage
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Width of the shared stall vector
    localparam int N_STALL = 6;

    // Position of each stage inside the stall vector
    typedef enum logic [2:0] {
        STG_PC  = 3'd0,
        STG_IF  = 3'd1,
        STG_ID  = 3'd2,
        STG_EX  = 3'd3,
        STG_MEM = 3'd4,
        STG_WB  = 3'd5
    } stage_e;

    // Action taken by a pipeline register on a clock edge
    typedef enum logic [1:0] {
        ACT_FLUSH  = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2,
        ACT_HOLD   = 2'd3
    } stage_act_e;

    // IF/ID payload
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // ID/EX payload
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [5:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    // EX/MEM payload
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    // MEM/WB payload
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; stop at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, asynchronously cleared
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic stall/flush-aware pipeline register (PIPE_STAGE_PERF_EN builds perf counters)
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VAL   = '0,
    parameter int                STAGE_IDX = 2,
    parameter int                N_STALL   = pipe_pkg::N_STALL,
    parameter int                CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_STALL-1:0] i_stall,
    input  logic               i_flush,
    input  logic [DATA_W-1:0]  i_up_data,
    input  logic               i_up_vld,
    input  logic               i_cnt_clr,
    output logic [DATA_W-1:0]  o_dn_data,
    output logic               o_dn_vld,
    output logic [CNT_W-1:0]   o_bubble_cnt,
    output logic [CNT_W-1:0]   o_hold_cnt
);

    import pipe_pkg::*;

    // The downstream stall bit must exist inside the vector
    generate
        if (STAGE_IDX < 0 || STAGE_IDX > N_STALL - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX out of range 0..N_STALL-2");
        end
    endgenerate

    logic              up_stall;
    logic              dn_stall;
    stage_act_e        act;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              vld_q;
    logic              vld_d;
    logic              bubble_inc;
    logic              hold_inc;

    assign up_stall = i_stall[STAGE_IDX];
    assign dn_stall = i_stall[STAGE_IDX+1];

    // Pick one action per edge in priority order, then derive next payload
    always_comb begin
        act    = ACT_HOLD;
        data_d = data_q;
        vld_d  = vld_q;
        if (i_flush) begin
            act    = ACT_FLUSH;
            data_d = NOP_VAL;
            vld_d  = 1'b0;
        end else if (up_stall == STOP && dn_stall == NO_STOP) begin
            act    = ACT_BUBBLE;
            data_d = NOP_VAL;
            vld_d  = 1'b0;
        end else if (up_stall == NO_STOP) begin
            act    = ACT_LOAD;
            data_d = i_up_data;
            vld_d  = i_up_vld;
        end
    end

    // Payload and valid registers, asynchronously reset to a bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= NOP_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign o_dn_data = data_q;
    assign o_dn_vld  = vld_q;

    assign bubble_inc = (act == ACT_BUBBLE);
    assign hold_inc   = (act == ACT_HOLD);

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (bubble_inc),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_bubble_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (hold_inc),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_hold_cnt)
    );

    logic unused_stall;
    assign unused_stall = ^i_stall;
`else
    assign o_bubble_cnt = '0;
    assign o_hold_cnt   = '0;

    logic unused_perf;
    assign unused_perf = ^{i_cnt_clr, bubble_inc, hold_inc, i_stall};
`endif

    // Upstream advancing into a frozen downstream stage is never generated by the stall controller
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(up_stall == NO_STOP && dn_stall == STOP));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int          DATA_W = 64;
    localparam int          CNT_W  = 4;
    localparam logic [63:0] NOP    = 64'hDEAD_BEEF_0000_0001;

    logic              clk;
    logic              rst_n;
    logic [5:0]        stall;
    logic              flush;
    logic [DATA_W-1:0] up_data;
    logic              up_vld;
    logic              cnt_clr;
    logic [DATA_W-1:0] dn_data;
    logic              dn_vld;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  hold_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .DATA_W    (DATA_W),
        .NOP_VAL   (NOP),
        .STAGE_IDX (2),
        .N_STALL   (6),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_up_data    (up_data),
        .i_up_vld     (up_vld),
        .i_cnt_clr    (cnt_clr),
        .o_dn_data    (dn_data),
        .o_dn_vld     (dn_vld),
        .o_bubble_cnt (bubble_cnt),
        .o_hold_cnt   (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [63:0] data;
        logic        vld;
        logic        clr;
        logic [63:0] exp_data;
        logic        exp_vld;
        logic [3:0]  exp_b;
        logic [3:0]  exp_h;
    } vec_t;

    vec_t vecs[12];

    // Counter expectation for this build: counters read 0 when not built
    function automatic logic [3:0] pc(input logic [3:0] x);
`ifdef PIPE_STAGE_PERF_EN
        return x;
`else
        return 4'd0 & x;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] ed, input logic ev,
                           input logic [3:0] eb, input logic [3:0] eh);
        chk({tag, " data"}, dn_data, ed);
        chk({tag, " vld"}, 64'(dn_vld), 64'(ev));
        chk({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'(pc(eb)));
        chk({tag, " hold_cnt"}, 64'(hold_cnt), 64'(pc(eh)));
    endtask

    task automatic apply(input logic [5:0] s, input logic f, input logic [63:0] d,
                         input logic v, input logic c);
        @(negedge clk);
        stall   = s;
        flush   = f;
        up_data = d;
        up_vld  = v;
        cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          stall      fl  data                 vld clr  exp_data             ev  b      h
        vecs[0]  = '{6'b000000, 0, 64'h1234,            1, 0,   64'h1234,            1, 4'd1 - 4'd1, 4'd0};
        vecs[1]  = '{6'b000100, 0, 64'h1111,            1, 0,   NOP,                 0, 4'd1, 4'd0};
        vecs[2]  = '{6'b000000, 0, 64'hABCD,            1, 0,   64'hABCD,            1, 4'd1, 4'd0};
        vecs[3]  = '{6'b001100, 0, 64'h9999,            1, 0,   64'hABCD,            1, 4'd1, 4'd1};
        vecs[4]  = '{6'b001100, 0, 64'h9999,            1, 0,   64'hABCD,            1, 4'd1, 4'd2};
        vecs[5]  = '{6'b001100, 0, 64'h9999,            1, 0,   64'hABCD,            1, 4'd1, 4'd3};
        vecs[6]  = '{6'b001100, 1, 64'h9999,            1, 0,   NOP,                 0, 4'd1, 4'd3};
        vecs[7]  = '{6'b000100, 1, 64'h8888,            1, 0,   NOP,                 0, 4'd1, 4'd3};
        vecs[8]  = '{6'b000000, 0, 64'h77,              0, 0,   64'h77,              0, 4'd1, 4'd3};
        vecs[9]  = '{6'b000000, 0, 64'h42,              1, 1,   64'h42,              1, 4'd0, 4'd0};
        vecs[10] = '{6'b110011, 0, 64'hFEED_0000_0000_005A, 1, 0, 64'hFEED_0000_0000_005A, 1, 4'd0, 4'd0};
        vecs[11] = '{6'b001100, 0, 64'h3333,            1, 1,   64'hFEED_0000_0000_005A, 1, 4'd0, 4'd0};

        rst_n   = 1'b0;
        stall   = '0;
        flush   = 1'b0;
        up_data = '0;
        up_vld  = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("reset", NOP, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].stall, vecs[i].flush, vecs[i].data, vecs[i].vld, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_vld,
                    vecs[i].exp_b, vecs[i].exp_h);
        end

        // 20 bubbles: bubble count saturates at 15
        for (int i = 0; i < 20; i++) begin
            apply(6'b000100, 1'b0, 64'h4444, 1'b1, 1'b0);
            chk($sformatf("sat%0d bubble_cnt", i), 64'(bubble_cnt),
                64'(pc((i + 1 > 15) ? 4'd15 : 4'(i + 1))));
        end
        chk_all("sat end", NOP, 1'b0, 4'd15, 4'd0);

        // Clear on the same cycle as another bubble reads 0
        apply(6'b000100, 1'b0, 64'h4444, 1'b1, 1'b1);
        chk_all("clr beats inc", NOP, 1'b0, 4'd0, 4'd0);

        // Load 0x55, hold, then asynchronous reset mid-hold
        apply(6'b000000, 1'b0, 64'h55, 1'b1, 1'b0);
        chk_all("load 55", 64'h55, 1'b1, 4'd0, 4'd0);
        apply(6'b001100, 1'b0, 64'h6666, 1'b1, 1'b0);
        apply(6'b001100, 1'b0, 64'h6666, 1'b1, 1'b0);
        chk_all("hold 55", 64'h55, 1'b1, 4'd0, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", NOP, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        stall   = 6'b000000;
        up_data = 64'h66;
        up_vld  = 1'b1;
        @(posedge clk);
        #1;
        chk_all("first load", 64'h66, 1'b1, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque payload plus a valid bit and obeys the shared 6-bit stall vector. Over the hand-written registers it adds a synchronous flush, a configurable bubble value and optional stall/bubble performance counters.

## Interface
Parameters:
- DATA_W, 64: payload width in bits; the instantiating stage packs its fields.
- NOP_VAL, '0: payload value loaded on a bubble or flush (DATA_W bits).
- STAGE_IDX, 2: index of the upstream stage in i_stall; legal range 0..N_STALL-2.
- N_STALL, 6: width of the stall vector.
- CNT_W, 16: performance counter width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_stall  in  N_STALL  per-stage stall vector; bit = STOP means that stage holds.
- i_flush  in  1  synchronous flush (exception/eret); kills the held instruction.
- i_up_data  in  DATA_W  payload from the upstream stage.
- i_up_vld  in  1  upstream payload is a real instruction.
- i_cnt_clr  in  1  synchronous clear of both counters.
- o_dn_data  out  DATA_W  registered payload to the downstream stage.
- o_dn_vld  out  1  registered valid.
- o_bubble_cnt  out  CNT_W  cycles in which a bubble was inserted.
- o_hold_cnt  out  CNT_W  cycles in which the register held.

## Operation
Let up = i_stall[STAGE_IDX] and dn = i_stall[STAGE_IDX+1]. Each posedge applies exactly one action, first match wins:
1. Reset (asynchronous): o_dn_data = NOP_VAL, o_dn_vld = 0, both counters = 0.
2. Flush (i_flush = 1): o_dn_data ← NOP_VAL, o_dn_vld ← 0. Flush overrides every stall combination.
3. Bubble (up = STOP, dn = NO_STOP): o_dn_data ← NOP_VAL, o_dn_vld ← 0. This means upstream is frozen while downstream advances.
4. Load (up = NO_STOP): o_dn_data ← i_up_data, o_dn_vld ← i_up_vld. A load is taken even when dn = STOP. The stall controller never produces that combination, so it is treated as don't-care for correctness and is flagged by an assertion.
5. Hold (up = STOP, dn = STOP): both outputs keep their value.

Counters:
- o_bubble_cnt increments on action 3 only. A flush does not count as a bubble.
- o_hold_cnt increments on action 5.
- Both counters saturate at 2^CNT_W−1 and do not wrap.
- i_cnt_clr = 1 forces both counters to 0 that cycle. Clear beats increment.
- Counters are unaffected by i_flush.

## Timing
- Latency is one cycle from input to output on a load.
- Outputs are purely registered, with no combinational path from any input to any output.
- A bubble or flush is visible on the outputs in the cycle after the qualifying edge.
- The hold state can last indefinitely; there is no timeout.
- Reset asserted mid-hold or mid-bubble clears the outputs immediately (asynchronously). The first load is permitted on the first edge after deassertion.
- Counter outputs update on the same edge as the action they count.

## Configuration
- PIPE_STAGE_PERF_EN defined: both saturating counters and i_cnt_clr logic are built.
- PIPE_STAGE_PERF_EN undefined: o_bubble_cnt and o_hold_cnt are tied to 0 and i_cnt_clr is ignored. The port list is identical in both builds, so stage wrappers need no change.

## Structure
- The shared package pipe_pkg holds:
  - STOP/NO_STOP constants.
  - N_STALL.
  - A stage index enum: STG_PC = 0, STG_IF = 1, STG_ID = 2, STG_EX = 3, STG_MEM = 4, STG_WB = 5.
  - Packed struct typedefs for each stage payload (id_ex_t, ex_mem_t, …), whose $bits drives DATA_W.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and clr), instantiated twice under PIPE_STAGE_PERF_EN.
- An elaboration-time check rejects STAGE_IDX > N_STALL−2.

## Test plan
- Reset, then a load with i_stall = 6'b000000, i_up_data = 64'h1234, i_up_vld = 1 → next cycle o_dn_data = 64'h1234, o_dn_vld = 1.
- STAGE_IDX = 2, i_stall = 6'b000100 for 1 cycle → o_dn_data = NOP_VAL, o_dn_vld = 0, o_bubble_cnt = 1.
- i_stall = 6'b001100 for 3 cycles after a load of 64'hABCD → outputs stay 64'hABCD/1 for 3 cycles, o_hold_cnt = 3.
- i_flush = 1 together with i_stall = 6'b001100 → outputs become NOP_VAL/0 next cycle; o_bubble_cnt and o_hold_cnt are unchanged.
- CNT_W = 4, 20 bubble cycles, then i_cnt_clr = 1 on the same cycle as a further bubble → count saturates at 15, then reads 0.
- Reset asserted during a hold of 64'h55 → outputs go to NOP_VAL/0 without waiting for a clock edge; the first edge after release loads i_up_data.
